// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch encodings, nop constant, default reset PC and queue entry layout
package fetch_unit_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INST         = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        misaligned;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction queue with wrap-around pointers and an occupancy count
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    assign do_pop = pop && cnt_q != '0;

    // pointer and count next state; flush empties the queue outright
    always_comb begin
        rd_d  = flush ? '0 : rd_q + AW'(do_pop);
        wr_d  = flush ? '0 : wr_q + AW'(push);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(do_pop);
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset: the head is only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = cnt_q == '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetcher with redirect flush and misaligned-target trap marker
// Optional build macro FETCH_BYPASS_EN: a response arriving at an empty queue is shown on fd_* the same cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetb,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] fd_inst,
    output logic [31:0] fd_pc,
    output logic        fd_misaligned,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, q_count;
    logic        mark_q, mark_d;
    logic        grant, take, mark_push, show_rsp, q_push, q_pop, q_empty;
    entry_t      rsp_entry, q_wdata, q_rdata, head;

    // state and datapath registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            mark_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            mark_q     <= mark_d;
        end
    end

    // a redirect picks the next state from target alignment; otherwise stay put
    always_comb begin
        state_d = redirect ? (redirect_pc[1:0] != 2'b00 ? HALTED : RUN) : state_q;
    end

    // issue only while running with room for every in-flight response; the marker enters once stale responses drain
    always_comb begin
        im_req    = resetb && state_q == RUN && !redirect && (int'(q_count) + int'(out_q) < DEPTH);
        mark_push = state_q == HALTED && mark_q && disc_q == '0 && !redirect;
    end

    assign grant = im_req && im_gnt;
    assign take  = im_rvalid && !redirect && disc_q == '0;

    // rsp_pc tracks the oldest unanswered live request; stale responses only burn the discard count
    always_comb begin
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + (grant ? 32'd4 : 32'd0);
        rsp_pc_d   = redirect ? redirect_pc : rsp_pc_q + (take ? 32'd4 : 32'd0);
        out_d      = out_q + CW'(grant) - CW'(im_rvalid);
        disc_d     = redirect ? out_q - CW'(im_rvalid) : disc_q - CW'(im_rvalid && disc_q != '0);
        mark_d     = redirect ? redirect_pc[1:0] != 2'b00 : mark_q && !mark_push;
    end

`ifdef FETCH_BYPASS_EN
    assign show_rsp = take && q_empty;
`else
    assign show_rsp = 1'b0;
`endif

    assign rsp_entry = {im_rdata, rsp_pc_q, 1'b0};
    assign q_wdata   = mark_push ? {NOP_INST, fetch_pc_q, 1'b1} : rsp_entry;
    assign q_push    = (take && !(show_rsp && fd_ready)) || mark_push;
    assign q_pop     = fd_ready && !redirect;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .clk    (clk),
        .resetb (resetb),
        .flush  (redirect),
        .push   (q_push),
        .pop    (q_pop),
        .wdata  (q_wdata),
        .rdata  (q_rdata),
        .count  (q_count),
        .empty  (q_empty)
    );

    assign head          = show_rsp ? rsp_entry : q_rdata;
    assign fd_valid      = !q_empty || show_rsp;
    assign fd_inst       = fd_valid ? head.inst : '0;
    assign fd_pc         = fd_valid ? head.pc : '0;
    assign fd_misaligned = fd_valid && head.misaligned;
    assign im_addr       = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked every cycle against a queue-level reference model
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        im_req, im_gnt = 1'b0, im_rvalid = 1'b0;
    logic [31:0] im_addr, im_rdata = '0;
    logic        fd_valid, fd_ready = 1'b0, fd_misaligned;
    logic [31:0] fd_inst, fd_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .resetb        (resetb),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_gnt        (im_gnt),
        .im_rvalid     (im_rvalid),
        .im_rdata      (im_rdata),
        .fd_valid      (fd_valid),
        .fd_ready      (fd_ready),
        .fd_inst       (fd_inst),
        .fd_pc         (fd_pc),
        .fd_misaligned (fd_misaligned),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic mis; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    ent_t        log_q[$];
    int          log_cyc[$];
    logic [31:0] m_pc;
    int          m_disc;
    logic        m_halt, m_mark;
    int          cyc, n_tests, n_fail;
    int          p_gnt, p_ready, p_rv, lat_lo, lat_hi;
    int          grants, reqs;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic knobs(input int g, input int r, input int v, input int lo, input int hi);
        p_gnt = g; p_ready = r; p_rv = v; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0; im_gnt = 1'b0; im_rvalid = 1'b0; redirect = 1'b0; fd_ready = 1'b0;
        #1;
        chk("rst_im_req", im_req, 0);
        chk("rst_im_addr", im_addr, RESET_PC);
        chk("rst_fd_valid", fd_valid, 0);
        chk("rst_fd_mis", fd_misaligned, 0);
        chk("rst_fd_inst", fd_inst, 0);
        chk("rst_fd_pc", fd_pc, 0);
        pend.delete(); mq.delete();
        m_pc = RESET_PC; m_disc = 0; m_halt = 1'b0; m_mark = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("first_req", im_req, 1);
        chk("first_addr", im_addr, RESET_PC);
    endtask

    // one clock of stimulus, full output comparison, then the model advances by that cycle's events
    task automatic step(input logic r, input logic [31:0] rp);
        logic rv, take, byp, exp_req, exp_valid, mark_now;
        ent_t view;
        req_t t;
        @(negedge clk);
        redirect    = r;
        redirect_pc = rp;
        im_gnt      = $urandom_range(99) < p_gnt;
        fd_ready    = $urandom_range(99) < p_ready;
        rv          = pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_rv;
        im_rvalid   = rv;
        im_rdata    = rv ? mem_word(pend[0].addr) : $urandom;
        #1;
        take      = rv && !r && m_disc == 0;
        byp       = BYP && take && mq.size() == 0;
        exp_req   = !m_halt && !r && (mq.size() + pend.size() < DEPTH);
        exp_valid = mq.size() > 0 || byp;
        view      = '{32'h0, 32'h0, 1'b0};
        if (mq.size() > 0) view = mq[0];
        else if (byp) view = '{mem_word(pend[0].addr), pend[0].addr, 1'b0};
        chk("im_req", im_req, exp_req);
        chk("im_addr", im_addr, m_pc);
        chk("fd_valid", fd_valid, exp_valid);
        if (exp_valid) begin
            chk("fd_pc", fd_pc, view.pc);
            chk("fd_inst", fd_inst, view.inst);
            chk("fd_mis", fd_misaligned, view.mis);
        end
        if (fd_valid && fd_ready && !r) begin
            log_q.push_back('{fd_inst, fd_pc, fd_misaligned});
            log_cyc.push_back(cyc);
        end
        if (im_req) reqs++;
        if (im_req && im_gnt) grants++;
        mark_now = m_halt && m_mark && m_disc == 0 && !r;
        if (r) begin
            if (rv) t = pend.pop_front();
            mq.delete();
            m_disc = pend.size();
            m_pc   = rp;
            m_halt = rp[1:0] != 2'b00;
            m_mark = m_halt;
        end else begin
            if (fd_ready && mq.size() > 0) void'(mq.pop_front());
            if (exp_req && im_gnt) begin
                pend.push_back('{m_pc, cyc + $urandom_range(lat_hi, lat_lo)});
                m_pc += 32'd4;
            end
            if (rv) begin
                t = pend.pop_front();
                if (m_disc > 0) m_disc--;
                else if (!(byp && fd_ready)) mq.push_back('{mem_word(t.addr), t.addr, 1'b0});
            end
            if (mark_now) begin
                mq.push_back('{32'h00000013, m_pc, 1'b1});
                m_mark = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r;
        logic [31:0] rp;
        int          k;
        n_tests = 0; n_fail = 0; cyc = 0; grants = 0; reqs = 0;
        knobs(100, 100, 100, 1, 1);
        do_reset();

        // streaming: one instruction per cycle after the first
        log_q.delete(); log_cyc.delete();
        step(1'b0, '0);
        step(1'b0, '0);
        chk("rsp_cycle_valid", fd_valid, BYP);
        step(1'b0, '0);
        chk("next_cycle_valid", fd_valid, 1);
        repeat (5) step(1'b0, '0);
        chk("stream_len_ok", log_q.size() >= 4, 1);
        if (log_q.size() >= 4) begin
            chk("stream_pc0", log_q[0].pc, 32'h0);
            chk("stream_pc1", log_q[1].pc, 32'h4);
            chk("stream_pc2", log_q[2].pc, 32'h8);
            chk("stream_pc3", log_q[3].pc, 32'hC);
            chk("stream_nogap", log_cyc[3] - log_cyc[0], 3);
        end

        // decode stalled: queue plus in-flight fills DEPTH and fetch stops
        do_reset();
        knobs(100, 0, 100, 1, 1);
        grants = 0;
        repeat (12) step(1'b0, '0);
        chk("stall_grants", grants, 4);
        chk("stall_req", im_req, 0);
        chk("stall_valid", fd_valid, 1);
        chk("stall_pc", fd_pc, 32'h0);

        // redirect with three long-latency requests in flight
        do_reset();
        knobs(100, 100, 100, 5, 5);
        repeat (3) step(1'b0, '0);
        chk("inflight3", pend.size(), 3);
        log_q.delete(); log_cyc.delete();
        step(1'b1, 32'h100);
        chk("discard3", m_disc, 3);
        knobs(100, 100, 100, 1, 3);
        k = 0;
        while (log_q.size() == 0 && k < 40) begin step(1'b0, '0); k++; end
        chk("redir_seen", log_q.size() > 0, 1);
        if (log_q.size() > 0) chk("redir_pc", log_q[0].pc, 32'h100);

        // misaligned target: one trap marker, no fetch until realigned
        log_q.delete(); log_cyc.delete();
        step(1'b1, 32'h102);
        reqs = 0;
        repeat (20) step(1'b0, '0);
        chk("mis_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("mis_pc", log_q[0].pc, 32'h102);
            chk("mis_flag", log_q[0].mis, 1);
            chk("mis_inst", log_q[0].inst, 32'h00000013);
        end
        chk("halt_reqs", reqs, 0);
        log_q.delete(); log_cyc.delete();
        step(1'b1, 32'h200);
        k = 0;
        while (log_q.size() == 0 && k < 40) begin step(1'b0, '0); k++; end
        chk("resume_seen", log_q.size() > 0, 1);
        if (log_q.size() > 0) chk("resume_pc", log_q[0].pc, 32'h200);

        // random traffic with redirects, misaligned targets and a mid-run reset
        knobs(70, 60, 75, 1, 4);
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            r  = $urandom_range(49) == 0;
            rp = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(3) == 0) rp[1:0] = 2'($urandom_range(3, 1));
            if (i % 500 == 250) knobs(100, 20, 100, 1, 2);
            if (i % 500 == 0) knobs(70, 60, 75, 1, 4);
            step(r, rp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
